// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and controller state encoding for alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_DIV    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// Runs WIDTH steps; o_done marks the final step, when o_hi/o_lo hold the
// sign-corrected results so the parent can capture them on that edge.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dbz,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // One multiply or divide step from the current partial state
    always_comb begin
        w_msum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
        w_shift   = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_shift >= {1'b0, r_d});
        w_step_hi = '0;
        w_step_lo = '0;
        if (r_div) begin
            w_step_hi = w_ge ? (w_shift[WIDTH-1:0] - r_d) : w_shift[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_step_hi = w_msum[WIDTH:1];
            w_step_lo = {w_msum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override of the final step
    always_comb begin
        w_prod = {w_step_hi, w_step_lo};
        if (r_neg_q) begin
            w_prod = -w_prod;
        end
        o_hi = w_prod[2*WIDTH-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            o_lo = r_neg_q ? -w_step_lo : w_step_lo;
            o_hi = r_neg_r ? -w_step_hi : w_step_hi;
            if (r_dbz) begin
                o_lo = '1;
                o_hi = r_a;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_dbz  = r_dbz;

    // Operand load on start, then one step per cycle while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_a     <= '0;
            r_d     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_busy) begin
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= i_div;
            r_neg_q <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= i_signed && i_a[WIDTH-1];
            r_dbz   <= i_div && (i_b == '0);
            r_a     <= i_a;
            r_d     <= i_div ? w_mag_b : w_mag_a;
            r_hi    <= '0;
            r_lo    <= i_div ? w_mag_a : w_mag_b;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative
// multiply/divide writing HI/LO, with registered result and flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             overflow_flag,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_e           r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic             w_accept;
    logic             w_it_start;
    logic             w_it_busy;
    logic             w_it_done;
    logic             w_it_dbz;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_lo;

    assign w_add = operand_a + operand_b;
    assign w_sub = operand_a - operand_b;

    // Opcode decode and single-cycle result
    always_comb begin
        w_res    = '0;
        w_ovf    = 1'b0;
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        case (op)
            OP_W'(OP_AND): w_res = operand_a & operand_b;
            OP_W'(OP_OR):  w_res = operand_a | operand_b;
            OP_W'(OP_NOR): w_res = ~(operand_a | operand_b);
            OP_W'(OP_ADD): begin
                w_res = w_add;
                w_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                        (w_add[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_W'(OP_SUB): begin
                w_res = w_sub;
                w_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_W'(OP_SLT): w_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_W'(OP_MULTU): w_is_mul = 1'b1;
            OP_W'(OP_MULT): begin
                w_is_mul = 1'b1;
                w_signed = 1'b1;
            end
            OP_W'(OP_DIVU): w_is_div = 1'b1;
            OP_W'(OP_DIV): begin
                w_is_div = 1'b1;
                w_signed = 1'b1;
            end
            OP_W'(OP_MFHI): w_res = r_hi;
            OP_W'(OP_MFLO): w_res = r_lo;
            default:        w_res = '0;
        endcase
    end

    // The done cycle (FINISH) accepts a new start exactly like IDLE
    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_FINISH));
    assign w_it_start = w_accept && (w_is_mul || w_is_div);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_it_start),
        .i_div    (w_is_div),
        .i_signed (w_signed),
        .i_a      (operand_a),
        .i_b      (operand_b),
        .o_busy   (w_it_busy),
        .o_done   (w_it_done),
        .o_dbz    (w_it_dbz),
        .o_hi     (w_it_hi),
        .o_lo     (w_it_lo)
    );

    // Controller FSM with registered result, flags, HI/LO and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FINISH: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else if (w_is_div) begin
                            r_state <= ST_DIV;
                        end else begin
                            r_result <= w_res;
                            r_zero   <= (w_res == '0);
                            r_neg    <= w_res[WIDTH-1];
                            r_ovf    <= w_ovf;
                            r_done   <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_it_done) begin
                        r_state  <= ST_FINISH;
                        r_hi     <= w_it_hi;
                        r_lo     <= w_it_lo;
                        r_result <= w_it_lo;
                        r_zero   <= (w_it_lo == '0);
                        r_neg    <= w_it_lo[WIDTH-1];
                        r_ovf    <= 1'b0;
                        r_done   <= 1'b1;
                        r_dbz    <= w_it_dbz;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result        = r_result;
    assign zero_flag     = r_zero;
    assign negative_flag = r_neg;
    assign overflow_flag = r_ovf;
    assign busy          = w_it_busy;
    assign done          = r_done;
    assign div_by_zero   = r_dbz;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, random ops against a
// behavioural model, and hand-written multi-cycle corner sequences.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start8;
    logic [3:0]  op, op8;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic [31:0] res;
    logic [7:0]  res8;
    logic        zf, nf, vf, busy, done, dbz;
    logic        zf8, nf8, vf8, busy8, done8, dbz8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .OP_W(4)) u_dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(a), .operand_b(b), .result(res),
        .zero_flag(zf), .negative_flag(nf), .overflow_flag(vf),
        .busy(busy), .done(done), .div_by_zero(dbz)
    );

    alu_seq #(.WIDTH(8), .OP_W(4)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .operand_a(a8), .operand_b(b8), .result(res8),
        .zero_flag(zf8), .negative_flag(nf8), .overflow_flag(vf8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit is_iter(input logic [3:0] o);
        return (o[3:2] == 2'b10);
    endfunction

    // Behavioural reference: plain 64-bit arithmetic on the spec's rules
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic v, output logic z);
        longint      sx, sy, s, lim;
        logic [63:0] t;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lim = 64'sd2147483648;
        r = '0; v = 1'b0; z = 1'b0;
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y);
            4'b0010: begin s = sx + sy; t = s; r = t[31:0]; v = (s >= lim) || (s < -lim); end
            4'b0110: begin s = sx - sy; t = s; r = t[31:0]; v = (s >= lim) || (s < -lim); end
            4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
            4'b1000: begin t = {32'd0, x} * {32'd0, y}; m_hi = t[63:32]; m_lo = t[31:0]; end
            4'b1001: begin s = sx * sy; t = s; m_hi = t[63:32]; m_lo = t[31:0]; end
            4'b1010, 4'b1011: begin
                if (y == 0) begin
                    m_lo = '1; m_hi = x; z = 1'b1;
                end else if (o == 4'b1010) begin
                    m_lo = x / y; m_hi = x % y;
                end else begin
                    s = sx / sy; t = s; m_lo = t[31:0];
                    s = sx % sy; t = s; m_hi = t[31:0];
                end
            end
            4'b1110: r = m_hi;
            4'b1111: r = m_lo;
            default: r = '0;
        endcase
        if (is_iter(o)) r = m_lo;
    endtask

    // Issue one op on the 32-bit DUT (caller sits just after an edge) and check completion
    task automatic run32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ev, input logic ez, input string nm);
        int lat;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), is_iter(o) ? 64'd33 : 64'd1);
        chk({nm, " result"}, {32'd0, res}, {32'd0, er});
        chk({nm, " zero"}, {63'd0, zf}, {63'd0, (er == 0)});
        chk({nm, " neg"}, {63'd0, nf}, {63'd0, er[31]});
        chk({nm, " ovf"}, {63'd0, vf}, {63'd0, ev});
        chk({nm, " dbz"}, {63'd0, dbz}, {63'd0, ez});
        chk({nm, " busy"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input string nm);
        int lat;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), is_iter(o) ? 64'd9 : 64'd1);
        chk({nm, " result"}, {56'd0, res8}, {56'd0, er});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] er;
        logic        ev, ez;
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        int          cnt;

        vecs.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0});
        vecs.push_back('{4'b1001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0, 1'b0});
        vecs.push_back('{4'b1110, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{4'b1111, 32'h0,        32'h0,        32'hFFFFFFF1, 1'b0, 1'b0});
        vecs.push_back('{4'b1011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back('{4'b1110, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{4'b1010, 32'h0000000A, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{4'b1110, 32'h0,        32'h0,        32'h0000000A, 1'b0, 1'b0});
        vecs.push_back('{4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{4'b1110, 32'h0,        32'h0,        32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{4'b0011, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
        vecs.push_back('{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
        vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{4'b1011, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back('{4'b1110, 32'h0,        32'h0,        32'h00000001, 1'b0, 1'b0});

        start = 1'b0; start8 = 1'b0; op = '0; op8 = '0;
        a = '0; b = '0; a8 = '0; b8 = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", {32'd0, res}, 64'd0);
        chk("reset flags", {61'd0, zf, nf, vf}, 64'd0);
        chk("reset busy_done_dbz", {61'd0, busy, done, dbz}, 64'd0);
        reset = 1'b0;

        // Directed table; the model only tracks HI/LO here
        foreach (vecs[i]) begin
            model(vecs[i].op, vecs[i].a, vecs[i].b, er, ev, ez);
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].dbz,
                  $sformatf("vec%0d", i));
        end

        // Result and flags hold between done pulses
        repeat (4) @(posedge clk);
        #1;
        chk("hold result", {32'd0, res}, 64'd1);
        chk("hold done", {63'd0, done}, 64'd0);

        // Random ops against the model, back-to-back in done cycles
        for (int i = 0; i < 250; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            model(ro, ra, rb, er, ev, ez);
            run32(ro, ra, rb, er, ev, ez, $sformatf("rnd%0d op%0h", i, ro));
        end

        // Start while busy is ignored
        op = 4'b1010; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy mid divu", {63'd0, busy}, 64'd1);
        op = 4'b0010; a = 32'd1; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 6;
        while (done !== 1'b1 && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("ignored start latency", 64'(cnt), 64'd33);
        chk("ignored start result", {32'd0, res}, 64'd14);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
        chk("ignored start extra done", 64'(cnt), 64'd0);
        model(4'b1010, 32'd100, 32'd7, er, ev, ez);
        run32(4'b1110, 32'd0, 32'd0, 32'd2, 1'b0, 1'b0, "divu remainder");

        // Reset mid-MULTU aborts without done
        op = 4'b1000; a = 32'h0000FFFF; b = 32'h0000FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("multu busy before reset", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort done", {63'd0, done}, 64'd0);
        chk("abort result", {32'd0, res}, 64'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) cnt++;
        end
        chk("abort no done", 64'(cnt), 64'd0);
        m_hi = '0;
        m_lo = '0;
        run32(4'b1110, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "abort hi");
        run32(4'b1111, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "abort lo");
        run32(4'b0010, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, "after abort add");

        // Narrow datapath build
        run8(4'b0111, 8'h80, 8'h01, 8'h01, "w8 slt");
        run8(4'b1000, 8'hFF, 8'hFF, 8'h01, "w8 multu");
        run8(4'b1110, 8'h00, 8'h00, 8'hFE, "w8 mfhi");
        run8(4'b1011, 8'h80, 8'hFF, 8'h80, "w8 div minneg");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
